// File: rtl/ui_input_conditioner.sv
// Pin conditioner for the UI controller: syncs, debounces and normalises KEY/SW, keeps sticky key-press flags.
// Optional macro UI_INPUT_IRQ_EN enables the registered irq output (otherwise irq is tied low).
module ui_input_conditioner #(
  parameter int NKEYS           = 4,
  parameter int NSW             = 10,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] key_raw,
  input  logic [NSW-1:0]   sw_raw,
  input  logic [NKEYS-1:0] press_clr,
  output logic [NKEYS-1:0] key_clean,
  output logic [NSW-1:0]   sw_clean,
  output logic [NKEYS-1:0] key_press,
  output logic             irq
);

  localparam int NB = NKEYS + NSW;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [NKEYS-1:0] key_lvl;
  logic [NB-1:0]    raw_lvl;
  logic [NB-1:0]    sync_p0;
  logic [NB-1:0]    sync_p1;
  logic [NB-1:0]    clean_p2;
  logic [CW-1:0]    cnt_p2 [NB];
  logic [NKEYS-1:0] key_clean_d;
  logic [NKEYS-1:0] rise;
  logic [NKEYS-1:0] press_q;
  logic [NKEYS-1:0] press_next;

  // Keys and switches share one sync/debounce path; keys sit in the low bits.
  assign key_lvl = (KEY_ACTIVE_LOW != 0) ? ~key_raw : key_raw;
  assign raw_lvl = {sw_raw, key_lvl};

  // Stage p0/p1: two-flop synchroniser
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw_lvl;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: per-bit debounce; any return to the accepted level restarts the count
  always_ff @(posedge clk) begin
    if (reset) begin
      clean_p2 <= '0;
      for (int i = 0; i < NB; i++) cnt_p2[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (sync_p1[i] == clean_p2[i]) begin
          cnt_p2[i] <= '0;
        end else if (cnt_p2[i] == CNT_MAX) begin
          clean_p2[i] <= sync_p1[i];
          cnt_p2[i]   <= '0;
        end else begin
          cnt_p2[i] <= cnt_p2[i] + CW'(1);
        end
      end
    end
  end

  // Stage p3: edge detect and sticky flags; a rise beats a simultaneous clear
  assign rise       = clean_p2[NKEYS-1:0] & ~key_clean_d;
  assign press_next = rise | (press_q & ~press_clr);

  always_ff @(posedge clk) begin
    if (reset) begin
      key_clean_d <= '0;
      press_q     <= '0;
    end else begin
      key_clean_d <= clean_p2[NKEYS-1:0];
      press_q     <= press_next;
    end
  end

`ifdef UI_INPUT_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= |press_next;
  end
`else
  assign irq = 1'b0;
`endif

  assign key_clean = clean_p2[NKEYS-1:0];
  assign sw_clean  = clean_p2[NB-1:NKEYS];
  assign key_press = press_q;

endmodule

// File: tb/tb_ui_input_conditioner.sv
// Bench for ui_input_conditioner: directed scenarios plus randomized traffic against a sliding-window reference model.
module tb_ui_input_conditioner;

  localparam int NKEYS = 4;
  localparam int NSW   = 10;
  localparam int DB    = 4;
  localparam int NB    = NKEYS + NSW;

  logic             clk = 1'b0;
  logic             reset;
  logic [NKEYS-1:0] key_raw;
  logic [NSW-1:0]   sw_raw;
  logic [NKEYS-1:0] press_clr;
  logic [NKEYS-1:0] key_clean;
  logic [NSW-1:0]   sw_clean;
  logic [NKEYS-1:0] key_press;
  logic             irq;

  ui_input_conditioner #(
    .NKEYS(NKEYS), .NSW(NSW), .DEBOUNCE_CYCLES(DB), .KEY_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .key_raw(key_raw), .sw_raw(sw_raw),
    .press_clr(press_clr), .key_clean(key_clean), .sw_clean(sw_clean),
    .key_press(key_press), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: history of active-high pin samples, one entry per clock edge (index 5 newest).
  logic [NB-1:0]    hist [0:5];
  logic [NB-1:0]    m_clean;
  logic [NKEYS-1:0] m_clean_d;
  logic [NKEYS-1:0] m_press;
  logic             m_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A level is accepted once the synchronised value has differed from the accepted level
  // for DB consecutive edges; the synchronised value at an edge is the pin sampled two edges earlier.
  task automatic model_step();
    logic [NB-1:0]    nxt;
    logic [NKEYS-1:0] r;
    if (reset) begin
      for (int k = 0; k < 6; k++) hist[k] = '0;
      m_clean = '0; m_clean_d = '0; m_press = '0; m_irq = 1'b0;
    end else begin
      nxt = m_clean;
      for (int b = 0; b < NB; b++) begin
        bit all_diff = 1'b1;
        for (int k = 1; k <= DB; k++)
          if (hist[5-k][b] == m_clean[b]) all_diff = 1'b0;
        if (all_diff) nxt[b] = ~m_clean[b];
      end
      r         = m_clean[NKEYS-1:0] & ~m_clean_d;
      m_press   = r | (m_press & ~press_clr);
`ifdef UI_INPUT_IRQ_EN
      m_irq     = |m_press;
`else
      m_irq     = 1'b0;
`endif
      m_clean_d = m_clean[NKEYS-1:0];
      m_clean   = nxt;
      for (int k = 0; k < 5; k++) hist[k] = hist[k+1];
      hist[5] = {sw_raw, ~key_raw};
    end
  endtask

  task automatic check_all();
    chk("key_clean", 32'(key_clean), 32'(m_clean[NKEYS-1:0]));
    chk("sw_clean",  32'(sw_clean),  32'(m_clean[NB-1:NKEYS]));
    chk("key_press", 32'(key_press), 32'(m_press));
    chk("irq",       32'(irq),       32'(m_irq));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  // Ticks until the selected clean bit goes high; returns the cycle count (budget-bounded).
  task automatic wait_clean(input int bitn, input int budget, output int n);
    n = 0;
    while ((key_clean_sw(bitn) !== 1'b1) && (n < budget)) begin
      tick();
      n++;
    end
  endtask

  function automatic logic key_clean_sw(input int bitn);
    logic [NB-1:0] v;
    v = {sw_clean, key_clean};
    return v[bitn];
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    logic exp_irq;
    reset = 1'b1; key_raw = 4'hF; sw_raw = '0; press_clr = '0;
    for (int k = 0; k < 6; k++) hist[k] = '0;
    m_clean = '0; m_clean_d = '0; m_press = '0; m_irq = 1'b0;
`ifdef UI_INPUT_IRQ_EN
    exp_irq = 1'b1;
`else
    exp_irq = 1'b0;
`endif

    // 1: reset with keys released
    repeat (3) tick();
    chk("rst_outputs", 32'({key_clean, sw_clean, key_press, irq}), 32'h0);
    reset = 1'b0;
    repeat (2) tick();
    chk("post_rst_outputs", 32'({key_clean, sw_clean, key_press, irq}), 32'h0);

    // 2: press key 0
    key_raw = 4'hE;
    wait_clean(0, 20, n);
    chk("key0_latency", 32'(n), 32'd6);
    chk("key0_clean", 32'(key_clean), 32'h1);
    chk("key0_press_not_yet", 32'(key_press[0]), 32'h0);
    tick();
    chk("key0_press", 32'(key_press[0]), 32'h1);
    chk("key0_irq", 32'(irq), 32'(exp_irq));

    // 3: switch 3 bouncing with 3-cycle pulses, then held
    for (int i = 0; i < 40; i++) begin
      sw_raw[3] = ((i % 6) < 3);
      tick();
      chk("sw_bounce", 32'(sw_clean), 32'h0);
    end
    sw_raw[3] = 1'b1;
    wait_clean(NKEYS + 3, 20, n);
    chk("sw3_latency", 32'(n), 32'd6);
    chk("sw3_clean", 32'(sw_clean), 32'h008);

    // 4: clear key 2 while held, then release and re-press
    key_raw = 4'hA;
    wait_clean(2, 20, n);
    chk("key2_latency", 32'(n), 32'd6);
    tick();
    chk("key2_press", 32'(key_press[2]), 32'h1);
    press_clr = 4'h4;
    tick();
    press_clr = 4'h0;
    chk("key2_cleared", 32'(key_press[2]), 32'h0);
    chk("key0_kept", 32'(key_press[0]), 32'h1);
    repeat (6) tick();
    chk("key2_held_stays_clear", 32'(key_press[2]), 32'h0);
    key_raw = 4'hE;
    repeat (8) tick();
    chk("key2_release_no_flag", 32'(key_press[2]), 32'h0);
    key_raw = 4'hA;
    wait_clean(2, 20, n);
    tick();
    chk("key2_repress", 32'(key_press[2]), 32'h1);

    // 5: clear key 1 in the cycle its rise is seen
    key_raw = 4'h8;
    repeat (5) tick();
    chk("key1_not_yet", 32'(key_clean[1]), 32'h0);
    tick();
    chk("key1_clean", 32'(key_clean[1]), 32'h1);
    chk("key1_press_pre", 32'(key_press[1]), 32'h0);
    press_clr = 4'h2;
    tick();
    press_clr = 4'h0;
    chk("key1_set_wins", 32'(key_press[1]), 32'h1);

    // 6: reset two cycles into key 3's debounce
    key_raw = 4'h0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_outputs", 32'({key_clean, sw_clean, key_press, irq}), 32'h0);
    reset = 1'b0;
    wait_clean(3, 20, n);
    chk("key3_after_rst_latency", 32'(n), 32'd6);
    chk("keys_after_rst", 32'(key_clean), 32'hF);
    chk("sw_after_rst", 32'(sw_clean), 32'h008);

    // Randomized traffic: slowly changing pins, random clears, occasional reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) key_raw[$urandom_range(0, NKEYS-1)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) sw_raw[$urandom_range(0, NSW-1)] ^= 1'b1;
      press_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    press_clr = 4'h0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
